// File: rtl/soda_pkg.sv
// Shared types and sizing helpers for the soda machine controller.
package soda_pkg;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_WAIT    = 3'd1,
        S_ADD     = 3'd2,
        S_DISP    = 3'd3,
        S_REFUND  = 3'd4,
        S_SOLDOUT = 3'd5
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TIMEOUT_DEF = 32;
    localparam int DISP_DEF    = 4;
    localparam int IDLE_W      = cnt_w(TIMEOUT_DEF);
    localparam int DISP_W      = cnt_w(DISP_DEF);

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; RST_VAL=1 suppresses an edge for a level
// that is already high when reset releases.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/soda_controller.sv
// Soda machine control FSM: loads coins into the datapath total, dispenses at
// price, refunds abandoned credit after a timeout and stops at the sale limit.
module soda_controller
    import soda_pkg::*;
#(
    parameter int W              = 4,
    parameter int MAX_SALES      = 15,
    parameter int DISP_CYCLES    = DISP_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         coin,
    input  logic         tot_lt_s,
    output logic         tot_ld,
    output logic         tot_clr,
    output logic         rst_counter,
    output logic         d,
    output logic         refund,
    output logic         coin_rej,
    output logic         sold_out,
    output logic [W-1:0] sales
);

    // Never narrower than the package defaults; wider is harmless.
    localparam int IDLE_CW = (cnt_w(TIMEOUT_CYCLES) > IDLE_W) ? cnt_w(TIMEOUT_CYCLES) : IDLE_W;
    localparam int DISP_CW = (cnt_w(DISP_CYCLES) > DISP_W) ? cnt_w(DISP_CYCLES) : DISP_W;

    localparam logic [W-1:0]       SALES_MAX = W'(MAX_SALES);
    localparam logic [W-1:0]       SALES_ONE = W'(1);
    localparam logic [IDLE_CW-1:0] IDLE_LAST = IDLE_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_CW-1:0] IDLE_ONE  = IDLE_CW'(1);
    localparam logic [DISP_CW-1:0] DISP_LAST = DISP_CW'(DISP_CYCLES - 1);
    localparam logic [DISP_CW-1:0] DISP_ONE  = DISP_CW'(1);

    state_e               state_q, state_d;
    logic                 credit_q, credit_d;
    logic [IDLE_CW-1:0]   idle_q, idle_d;
    logic [DISP_CW-1:0]   disp_q, disp_d;
    logic [W-1:0]         sales_q, sales_d;
    logic                 coin_rej_q, coin_rej_d;
    logic                 coin_edge;

    rise_detect #(
        .RST_VAL (1'b1)
    ) u_coin_rise (
        .clk_i  (clk),
        .rst_i  (rst),
        .sig_i  (coin),
        .rise_o (coin_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            credit_q   <= 1'b0;
            idle_q     <= '0;
            disp_q     <= '0;
            sales_q    <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            idle_q     <= idle_d;
            disp_q     <= disp_d;
            sales_q    <= sales_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        idle_d      = idle_q;
        disp_d      = disp_q;
        sales_d     = sales_q;
        coin_rej_d  = 1'b0;
        tot_ld      = 1'b0;
        tot_clr     = 1'b0;
        rst_counter = 1'b0;
        d           = 1'b0;
        refund      = 1'b0;
        sold_out    = 1'b0;

        unique case (state_q)
            S_INIT: begin
                tot_clr     = 1'b1;
                rst_counter = 1'b1;
                coin_rej_d  = coin_edge;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (sales_q == SALES_MAX) begin
                    state_d = S_SOLDOUT;
                end else if (coin_edge) begin
                    state_d = S_ADD;
                end else if (!tot_lt_s) begin
                    disp_d  = '0;
                    state_d = S_DISP;
                end else if (credit_q && (idle_q == IDLE_LAST)) begin
                    state_d = S_REFUND;
                end else if (credit_q) begin
                    idle_d = idle_q + IDLE_ONE;
                end
            end
            S_ADD: begin
                tot_ld   = 1'b1;
                credit_d = 1'b1;
                idle_d   = '0;
                state_d  = S_WAIT;
            end
            S_DISP: begin
                d          = 1'b1;
                coin_rej_d = coin_edge;
                if (disp_q == DISP_LAST) begin
                    // Clearing the total on the final cycle keeps WAIT from re-dispensing.
                    tot_clr  = 1'b1;
                    sales_d  = (sales_q == SALES_MAX) ? sales_q : sales_q + SALES_ONE;
                    credit_d = 1'b0;
                    idle_d   = '0;
                    disp_d   = '0;
                    state_d  = S_WAIT;
                end else begin
                    disp_d = disp_q + DISP_ONE;
                end
            end
            S_REFUND: begin
                refund     = 1'b1;
                tot_clr    = 1'b1;
                credit_d   = 1'b0;
                idle_d     = '0;
                coin_rej_d = coin_edge;
                state_d    = S_WAIT;
            end
            S_SOLDOUT: begin
                sold_out   = 1'b1;
                coin_rej_d = coin_edge;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign coin_rej = coin_rej_q;
    assign sales    = sales_q;

endmodule
